// File: rtl/wb_port_arbiter.sv
// Purpose : shares the single register-file write port between the in-order pipeline and a queued multi-cycle unit.
// Latency : granted source appears on regWrite/writeAddr/writeData one edge later; an mc result is written 2 edges after it is presented, at the earliest.
// Backpress: o_mcReady = !full (no pass-through when full); o_pipeStall holds the pipeline during a one-cycle forced FIFO drain.
//
// Ports:
//   i_clk, i_reset                  clock, synchronous active-high reset
//   i_pipeValid/Addr/Data           pipeline write-back request (priority source)
//   o_pipeStall                     pipeline must hold its request this cycle
//   i_mcValid/Addr/Data, o_mcReady  multi-cycle result, valid/ready handshake into the FIFO
//   o_regWrite/o_writeAddr/o_writeData  registered register-file write port
//   i_lookupAddr, o_pendingHit      RAW hazard lookup, present only with WB_ARB_HAZARD_EN defined
module wb_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_pipeValid,
    input  logic [ADDR_W-1:0] i_pipeAddr,
    input  logic [DATA_W-1:0] i_pipeData,
    output logic              o_pipeStall,
    input  logic              i_mcValid,
    output logic              o_mcReady,
    input  logic [ADDR_W-1:0] i_mcAddr,
    input  logic [DATA_W-1:0] i_mcData,
`ifdef WB_ARB_HAZARD_EN
    input  logic [ADDR_W-1:0] i_lookupAddr,
    output logic              o_pendingHit,
`endif
    output logic              o_regWrite,
    output logic [ADDR_W-1:0] o_writeAddr,
    output logic [DATA_W-1:0] o_writeData
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);

    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_FORCE  = 1'b1;

    logic [ADDR_W-1:0] r_fifoAddr [DEPTH];
    logic [DATA_W-1:0] r_fifoData [DEPTH];
    logic [PW-1:0]     r_wrPtr;
    logic [PW-1:0]     r_rdPtr;
    logic [CW-1:0]     r_count;
    logic [SW-1:0]     r_starveCnt;
    logic [0:0]        r_state;
    logic              r_regWrite;
    logic [ADDR_W-1:0] r_writeAddr;
    logic [DATA_W-1:0] r_writeData;

    logic w_empty;
    logic w_full;
    logic w_enq;
    logic w_grantPipe;
    logic w_grantFifo;
    logic w_fifoLoses;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(DEPTH));
    // Ready depends on current occupancy only, so a full FIFO refuses even on a dequeue cycle.
    assign o_mcReady   = !w_full;
    assign w_enq       = i_mcValid && !w_full;
    assign w_fifoLoses = !w_empty && !w_grantFifo;

    always_comb begin
        w_grantPipe = 1'b0;
        w_grantFifo = 1'b0;
        o_pipeStall = 1'b0;
        if (r_state == ST_FORCE) begin
            w_grantFifo = !w_empty;
            o_pipeStall = i_pipeValid && !i_reset;
        end else if (i_pipeValid) begin
            w_grantPipe = 1'b1;
        end else begin
            w_grantFifo = !w_empty;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are meaningful.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_enq) begin
            r_fifoAddr[r_wrPtr] <= i_mcAddr;
            r_fifoData[r_wrPtr] <= i_mcData;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_starveCnt <= '0;
            r_state     <= ST_NORMAL;
            r_regWrite  <= 1'b0;
            r_writeAddr <= '0;
            r_writeData <= '0;
        end else begin
            if (w_enq) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_grantFifo) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            case ({w_enq, w_grantFifo})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            // Saturates at the trip value; the forced drain that follows clears it.
            if (!w_fifoLoses) begin
                r_starveCnt <= '0;
            end else if (r_starveCnt != STARVE_LAST) begin
                r_starveCnt <= r_starveCnt + SW'(1);
            end

            if (r_state == ST_NORMAL && w_fifoLoses && r_starveCnt == STARVE_LAST) begin
                r_state <= ST_FORCE;
            end else begin
                r_state <= ST_NORMAL;
            end

            // A granted write to r0 still consumes its source but never enables the write.
            if (w_grantPipe) begin
                r_regWrite  <= (i_pipeAddr != '0);
                r_writeAddr <= i_pipeAddr;
                r_writeData <= i_pipeData;
            end else if (w_grantFifo) begin
                r_regWrite  <= (r_fifoAddr[r_rdPtr] != '0);
                r_writeAddr <= r_fifoAddr[r_rdPtr];
                r_writeData <= r_fifoData[r_rdPtr];
            end else begin
                r_regWrite  <= 1'b0;
            end
        end
    end

`ifdef WB_ARB_HAZARD_EN
    // Walk entries by offset from the head so only occupied slots can match.
    always_comb begin
        o_pendingHit = 1'b0;
        if (i_lookupAddr != '0) begin
            if (r_regWrite && r_writeAddr == i_lookupAddr) begin
                o_pendingHit = 1'b1;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) < r_count && r_fifoAddr[r_rdPtr + PW'(i)] == i_lookupAddr) begin
                    o_pendingHit = 1'b1;
                end
            end
        end
    end
`endif

    assign o_regWrite  = r_regWrite;
    assign o_writeAddr = r_writeAddr;
    assign o_writeData = r_writeData;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Purpose : exercises wb_port_arbiter with directed scenarios and random traffic against a queue-based model.
// Latency : one model step per clock; registered outputs compared 1 time unit after each rising edge.
// Backpress: stimulus requests are held in source queues until the model says they were accepted.
module tb_wb_port_arbiter;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              i_reset;
    logic              i_pipeValid;
    logic [ADDR_W-1:0] i_pipeAddr;
    logic [DATA_W-1:0] i_pipeData;
    logic              o_pipeStall;
    logic              i_mcValid;
    logic              o_mcReady;
    logic [ADDR_W-1:0] i_mcAddr;
    logic [DATA_W-1:0] i_mcData;
    logic [ADDR_W-1:0] i_lookupAddr;
    logic              o_pendingHit;
    logic              o_regWrite;
    logic [ADDR_W-1:0] o_writeAddr;
    logic [DATA_W-1:0] o_writeData;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .i_clk(clk),
        .i_reset(i_reset),
        .i_pipeValid(i_pipeValid),
        .i_pipeAddr(i_pipeAddr),
        .i_pipeData(i_pipeData),
        .o_pipeStall(o_pipeStall),
        .i_mcValid(i_mcValid),
        .o_mcReady(o_mcReady),
        .i_mcAddr(i_mcAddr),
        .i_mcData(i_mcData),
`ifdef WB_ARB_HAZARD_EN
        .i_lookupAddr(i_lookupAddr),
        .o_pendingHit(o_pendingHit),
`endif
        .o_regWrite(o_regWrite),
        .o_writeAddr(o_writeAddr),
        .o_writeData(o_writeData)
    );

`ifndef WB_ARB_HAZARD_EN
    assign o_pendingHit = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int stall_seen = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Stimulus sources: head is presented, popped only when accepted.
    logic [ADDR_W-1:0] ps_a[$];
    logic [DATA_W-1:0] ps_d[$];
    logic [ADDR_W-1:0] mcs_a[$];
    logic [DATA_W-1:0] mcs_d[$];

    // Reference model: result queue, starvation count, pending-force flag, output register.
    logic [ADDR_W-1:0] mq_a[$];
    logic [DATA_W-1:0] mq_d[$];
    bit                m_force = 1'b0;
    int                m_starve = 0;
    bit                m_rw = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_data = '0;
    bit                m_known = 1'b1;

    task automatic cycle(input bit rst, input logic [ADDR_W-1:0] la);
        bit pv, mv, rdy, stall, hit, gp, gf, loses, nf;
        logic [ADDR_W-1:0] ga;
        logic [DATA_W-1:0] gd;
        pv = ps_a.size() > 0;
        mv = mcs_a.size() > 0;
        i_reset      = rst;
        i_pipeValid  = pv;
        i_pipeAddr   = pv ? ps_a[0] : ADDR_W'($urandom);
        i_pipeData   = pv ? ps_d[0] : $urandom;
        i_mcValid    = mv;
        i_mcAddr     = mv ? mcs_a[0] : ADDR_W'($urandom);
        i_mcData     = mv ? mcs_d[0] : $urandom;
        i_lookupAddr = la;
        #3;
        rdy   = mq_a.size() < DEPTH;
        stall = m_force && pv && !rst;
        check_eq("mcReady", o_mcReady, rdy);
        check_eq("pipeStall", o_pipeStall, stall);
        if (o_pipeStall) stall_seen++;
`ifdef WB_ARB_HAZARD_EN
        hit = (la != 0) && m_rw && (m_addr == la);
        foreach (mq_a[i]) if (la != 0 && mq_a[i] == la) hit = 1'b1;
        check_eq("pendingHit", o_pendingHit, hit);
`endif
        if (rst) begin
            mq_a.delete();
            mq_d.delete();
            m_force = 0; m_starve = 0; m_rw = 0; m_addr = '0; m_data = '0; m_known = 1;
        end else begin
            gp = 0;
            gf = 0;
            if (m_force) gf = mq_a.size() > 0;
            else if (pv) gp = 1;
            else gf = mq_a.size() > 0;
            loses = (mq_a.size() > 0) && !gf;
            nf = !m_force && loses && (m_starve == STARVE_MAX - 1);
            if (!loses) m_starve = 0;
            else if (m_starve < STARVE_MAX - 1) m_starve++;
            m_force = nf;
            if (gp) begin
                ga = ps_a.pop_front();
                gd = ps_d.pop_front();
            end else if (gf) begin
                ga = mq_a.pop_front();
                gd = mq_d.pop_front();
            end
            if (gp || gf) begin
                m_rw = (ga != 0);
                m_addr = ga;
                m_data = gd;
                m_known = m_rw;
            end else begin
                m_rw = 0;
            end
            if (mv && rdy) begin
                mq_a.push_back(mcs_a.pop_front());
                mq_d.push_back(mcs_d.pop_front());
            end
        end
        @(posedge clk);
        #1;
        check_eq("regWrite", o_regWrite, m_rw);
        if (m_known) begin
            check_eq("writeAddr", o_writeAddr, m_addr);
            check_eq("writeData", o_writeData, m_data);
        end
    endtask

    initial begin
        i_reset = 1'b1; i_pipeValid = 1'b0; i_pipeAddr = '0; i_pipeData = '0;
        i_mcValid = 1'b0; i_mcAddr = '0; i_mcData = '0; i_lookupAddr = '0;
        @(posedge clk);
        #1;

        // Reset held with an mc result offered: nothing may be taken in.
        mcs_a.push_back(5'd31); mcs_d.push_back(32'hCAFE0001);
        cycle(1, '0);
        cycle(1, '0);
        mcs_a.delete(); mcs_d.delete();
        cycle(0, '0);
        check_eq("t1_regWrite", o_regWrite, 0);

        // Single pipeline write.
        ps_a.push_back(5'd3); ps_d.push_back(32'hDEADBEEF);
        cycle(0, '0);
        check_eq("t2_addr", o_writeAddr, 3);
        check_eq("t2_data", o_writeData, 32'hDEADBEEF);

        // Lone mc result: written two edges after it is presented.
        mcs_a.push_back(5'd7); mcs_d.push_back(32'h12345678);
        cycle(0, '0);
        check_eq("t3_early", o_regWrite, 0);
        cycle(0, '0);
        check_eq("t3_rw", o_regWrite, 1);
        check_eq("t3_addr", o_writeAddr, 7);

        // Held pipeline vs one queued result: exactly one forced drain.
        stall_seen = 0;
        for (int i = 1; i <= 8; i++) begin
            ps_a.push_back(ADDR_W'(i)); ps_d.push_back($urandom);
        end
        mcs_a.push_back(5'd9); mcs_d.push_back(32'h99990009);
        for (int k = 0; k < 40 && (ps_a.size() > 0 || mq_a.size() > 0); k++) cycle(0, '0);
        check_eq("t4_drained", ps_a.size() + mq_a.size(), 0);
        check_eq("t4_stalls", stall_seen, 1);

        // Three back-to-back mc results against a held pipeline.
        for (int i = 0; i < 14; i++) begin
            ps_a.push_back(ADDR_W'(10 + i)); ps_d.push_back($urandom);
        end
        for (int i = 0; i < 3; i++) begin
            mcs_a.push_back(ADDR_W'(20 + i)); mcs_d.push_back($urandom);
        end
        for (int k = 0; k < 80 && (ps_a.size() + mcs_a.size() + mq_a.size()) > 0; k++) cycle(0, '0);
        check_eq("t5_drained", ps_a.size() + mcs_a.size() + mq_a.size(), 0);

        // Write to r0 consumes the request without enabling the write.
        ps_a.push_back(5'd0); ps_d.push_back(32'h0BAD0BAD);
        cycle(0, '0);
        check_eq("t6_r0", o_regWrite, 0);

        // Pending-hazard lookup on a queued result, then with lookup address 0.
        ps_a.push_back(5'd1); ps_d.push_back(32'h1);
        ps_a.push_back(5'd2); ps_d.push_back(32'h2);
        mcs_a.push_back(5'd5); mcs_d.push_back(32'h55);
        for (int k = 0; k < 6; k++) cycle(0, 5'd5);
        mcs_a.push_back(5'd5); mcs_d.push_back(32'h56);
        for (int k = 0; k < 3; k++) cycle(0, 5'd0);

        // Random traffic with occasional mid-stream resets.
        for (int k = 0; k < 3000; k++) begin
            if (ps_a.size() == 0 && ($urandom % 3) != 0) begin
                ps_a.push_back(ADDR_W'($urandom % 8)); ps_d.push_back($urandom);
            end
            if (mcs_a.size() == 0 && ($urandom % 3) == 0) begin
                mcs_a.push_back(ADDR_W'($urandom % 8)); mcs_d.push_back($urandom);
            end
            cycle(($urandom % 150) == 0, ADDR_W'($urandom % 8));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
